keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Scans a 4x4 matrix keypad by driving one active-low row at a time and reading active-low columns.
//  Debounces the press and the release of each key, then emits one key code per press on a valid/ack handshake.
//  Keeps a 3-digit 8421 BCD entry buffer that feeds the 7-segment scanner's num[11:0] input.
//  Sits on the board user-interface side, next to the display driver.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per scan tick (1 ms at 50 MHz); must be >= 2
//  DEB_TICKS  16     consecutive stable ticks needed to accept a press or a release; must be >= 1
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  col_n      in   4   keypad columns, active-low, pulled up externally, asynchronous to clk
//  row_n      out  4   keypad row drive, active-low, at most one bit low
//  key_code   out  4   code of the accepted key, stable while key_valid=1
//  key_valid  out  1   key_code holds an unacknowledged key
//  key_ack    in   1   consumer accepts key_code; has effect only while key_valid=1
//  overrun    out  1   sticky; a new key was accepted while key_valid=1 and no ack
//  num        out  12  BCD entry buffer {hundreds,tens,units}
// BEHAVIOUR
//  Reset values: row_n=4'b1111, key_code=0, key_valid=0, overrun=0, num=0, FSM=SCAN, all counters=0.
//  Keymap, code={row,col} decoded to a value:
//   r0: 1 2 3 A;  r1: 4 5 6 B;  r2: 7 8 9 C;  r3: * 0 # D.
//   Digits give 0-9; A-D give 10-13; * gives 14; # gives 15.
//  Tick: a prescaler counts 0..SCAN_DIV-1 and asserts tick for one clk when count==SCAN_DIV-1, then wraps.
//  col_n passes through a 2-flop synchronizer (col_s). Columns are evaluated only on tick.
//  SCAN: on tick, if col_s has any bit low:
//   - latch the row index and the lowest-index low column;
//   - go to DEBOUNCE with deb_cnt=1 and row_n held.
//   Otherwise advance row_n: 1111->1110->1101->1011->0111->1110...
//  DEBOUNCE: on tick, if the latched column is still low:
//   - when deb_cnt==DEB_TICKS, go to PRESS;
//   - otherwise increment deb_cnt.
//   If the latched column is high, go to SCAN and advance the row.
//   With DEB_TICKS=1, go straight from SCAN to PRESS on the same tick.
//  PRESS: lasts exactly one clk, then go to RELEASE with rel_cnt=0.
//   Handshake on the PRESS cycle:
//   - if key_valid=0, or key_ack=1 on this cycle: load key_code and set key_valid=1;
//   - otherwise keep the old key_code and set overrun=1.
//   Buffer update on the PRESS cycle, applied even on overrun:
//   - digit d: num <= {num[7:0],d};
//   - * : num <= 0;
//   - # : num <= {4'h0,num[11:4]} (backspace);
//   - A-D: num unchanged.
//  RELEASE: row_n held.
//   - on tick, if all col_s are high, increment rel_cnt; at rel_cnt==DEB_TICKS go to SCAN and advance the row;
//   - if any col_s is low, reset rel_cnt to 0.
//  Handshake outside PRESS: key_valid=1 && key_ack=1 clears key_valid and overrun on the next edge.
//   key_ack is ignored while key_valid=0.
//  Each press yields exactly one code, regardless of hold time. No auto-repeat.
//  Simultaneous keys: the lowest column of the first row found wins. Other keys are ignored until all keys are released.
//  A FSM move out of SCAN never changes row_n on that tick; row_n changes only on SCAN ticks and on exits to SCAN.
//  Reset asserted mid-operation returns every register to its reset value asynchronously. No key is emitted.
// STRUCTURE
//  Shared header keypad_defs.vh holds:
//   - FSM state encodings SCAN/DEBOUNCE/PRESS/RELEASE (2 bits);
//   - KEY_STAR=4'd14, KEY_HASH=4'd15;
//   - the row rotation reset value 4'b1111.
//  One sub-module, keypad_tick: a parameterised prescaler (SCAN_DIV) that outputs the 1-clk tick.
//  The synchronizer, FSM, keymap, handshake and BCD buffer stay in keypad_scan.
// TESTING
//  The bench uses SCAN_DIV=4 and DEB_TICKS=3, with a keypad model that pulls col c low when row r is low and key (r,c) is down.
//  1 Idle after reset:
//    - row_n steps 1110,1101,1011,0111,1110 once every 4 clk;
//    - key_valid=0, num=0.
//  2 Press "5" (r1,c1), hold, then release:
//    - key_valid rises after 3 stable ticks with key_code=5, num=12'h005;
//    - no further code while held;
//    - the next key is accepted only after 3 all-high ticks.
//  3 Bounce: toggle c1 low 1 tick, high 1 tick, repeated 4 times, then release:
//    - key_valid stays 0 and num is unchanged.
//  4 Enter 1,2,3,4, acking each:
//    - num goes 001,012,123,234 (hex);
//    - then # gives num=023, then * gives num=000.
//  5 Press 7 with no ack, then press 8:
//    - key_code stays 7, overrun=1, num=078;
//    - ack clears key_valid and overrun on the next clk.
//  6 Assert rst during DEBOUNCE of key 9:
//    - all outputs return to reset values immediately;
//    - no code is emitted after rst is released while the key is held; after release and re-press, 9 is accepted.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: FSM states, special key codes and scan helpers shared by the keypad scanner.
package keypad_scan_pkg;
  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, PRESS = 2'd2, RELEASE = 2'd3} state_t;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  localparam logic [3:0] ROW_RST = 4'b1111;
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'd1;
      4'h1: k = 4'd2;
      4'h2: k = 4'd3;
      4'h3: k = 4'd10;
      4'h4: k = 4'd4;
      4'h5: k = 4'd5;
      4'h6: k = 4'd6;
      4'h7: k = 4'd11;
      4'h8: k = 4'd7;
      4'h9: k = 4'd8;
      4'ha: k = 4'd9;
      4'hb: k = 4'd12;
      4'hc: k = KEY_STAR;
      4'hd: k = 4'd0;
      4'he: k = KEY_HASH;
      default: k = 4'd13;
    endcase
    return k;
  endfunction
  function automatic logic [3:0] next_row(input logic [3:0] row_n);
    return (row_n == ROW_RST) ? 4'b1110 : {row_n[2:0], row_n[3]};
  endfunction
  // Index of the lowest zero bit; used for both the driven row and the pressed column.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_scan_tick.sv
// keypad_tick: prescaler emitting a one-clk tick every SCAN_DIV cycles.
module keypad_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(SCAN_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad scanner with press/release debounce, valid/ack key output and BCD entry buffer.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        overrun,
  output logic [11:0] num
);
  localparam int CW = $clog2(DEB_TICKS + 1);
  logic tick;
  logic [3:0] col_m_q, col_s_q;
  state_t state_q, state_d;
  logic [3:0] row_n_q, row_n_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d, rel_cnt_q, rel_cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic key_valid_q, key_valid_d, overrun_q, overrun_d;
  logic [11:0] num_q, num_d;
  logic any_low, held_low, press, accept, ack_hit;
  logic [3:0] code;
  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_m_q <= 4'hf;
      col_s_q <= 4'hf;
      state_q <= SCAN;
      row_n_q <= ROW_RST;
      row_q <= '0;
      col_q <= '0;
      deb_cnt_q <= '0;
      rel_cnt_q <= '0;
      key_code_q <= '0;
      key_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      num_q <= '0;
    end else begin
      col_m_q <= col_n;
      col_s_q <= col_m_q;
      state_q <= state_d;
      row_n_q <= row_n_d;
      row_q <= row_d;
      col_q <= col_d;
      deb_cnt_q <= deb_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      key_code_q <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q <= overrun_d;
      num_q <= num_d;
    end
  // Counters compare against DEB_TICKS-1: the current tick is the one that completes the run.
  always_comb begin
    state_d = state_q;
    row_n_d = row_n_q;
    row_d = row_q;
    col_d = col_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    any_low = ~&col_s_q;
    held_low = ~col_s_q[col_q];
    case (state_q)
      SCAN:
        if (tick) begin
          if (any_low) begin
            row_d = low_idx(row_n_q);
            col_d = low_idx(col_s_q);
            deb_cnt_d = CW'(1);
            state_d = (DEB_TICKS == 1) ? PRESS : DEBOUNCE;
          end else row_n_d = next_row(row_n_q);
        end
      DEBOUNCE:
        if (tick) begin
          if (!held_low) begin
            state_d = SCAN;
            row_n_d = next_row(row_n_q);
          end else if (deb_cnt_q == CW'(DEB_TICKS - 1)) state_d = PRESS;
          else deb_cnt_d = deb_cnt_q + 1'b1;
        end
      PRESS: begin
        state_d = RELEASE;
        rel_cnt_d = '0;
      end
      default:
        if (tick) begin
          if (any_low) rel_cnt_d = '0;
          else if (rel_cnt_q == CW'(DEB_TICKS - 1)) begin
            rel_cnt_d = '0;
            state_d = SCAN;
            row_n_d = next_row(row_n_q);
          end else rel_cnt_d = rel_cnt_q + 1'b1;
        end
    endcase
  end
  always_comb begin
    press = state_q == PRESS;
    code = key_map(row_q, col_q);
    accept = ~key_valid_q | key_ack;
    ack_hit = key_valid_q & key_ack;
    key_code_d = (press && accept) ? code : key_code_q;
    key_valid_d = press | (key_valid_q & ~key_ack);
    overrun_d = (press & ~accept) | (overrun_q & ~ack_hit);
    num_d = !press ? num_q :
            (code == KEY_STAR) ? 12'h000 :
            (code == KEY_HASH) ? {4'h0, num_q[11:4]} :
            (code < 4'd10) ? {num_q[7:0], code} : num_q;
  end
  assign row_n = row_n_q;
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun = overrun_q;
  assign num = num_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed keypad scenarios with a matrix model and an expected-key scoreboard.
module tb_keypad_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] col_n, row_n, key_code;
  logic key_valid, key_ack, overrun;
  logic [11:0] num;
  logic [15:0] down = '0;
  logic [11:0] num_m = '0;
  logic [3:0] kmap [16] = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
                            4'd7, 4'd8, 4'd9, 4'd12, 4'd14, 4'd0, 4'd15, 4'd13};
  typedef struct packed {logic [3:0] code; logic [11:0] num;} exp_t;
  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  keypad_scan #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .overrun(overrun), .num(num)
  );
  always #5 clk = ~clk;
  always_comb begin
    col_n = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (down[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [11:0] upd(input logic [11:0] n, input logic [3:0] k);
    if (k == 4'd14) return 12'h000;
    if (k == 4'd15) return {4'h0, n[11:4]};
    if (k < 4'd10) return {n[7:0], k};
    return n;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic align(input int r);
    logic [3:0] tgt;
    int t;
    tgt = ~(4'b0001 << r);
    t = 0;
    while (row_n == tgt && t < 200) begin @(negedge clk); t++; end
    while (row_n != tgt && t < 200) begin @(negedge clk); t++; end
    chk("align_timeout", 16'(t < 200), 16'd1);
  endtask
  task automatic press(input int r, input int c);
    logic was_valid;
    logic [3:0] k;
    exp_t e;
    align(r);
    down[r*4+c] = 1'b1;
    k = kmap[r*4+c];
    num_m = upd(num_m, k);
    was_valid = key_valid;
    if (!was_valid) sb.push_back('{k, num_m});
    repeat (12) @(negedge clk);
    if (!was_valid) chk("valid_early", 16'(key_valid), 16'd0);
    @(negedge clk);
    if (!was_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("valid_rise", 16'(key_valid), 16'd1);
      chk("key_code", 16'(key_code), 16'(e.code));
      chk("num", 16'(num), 16'(e.num));
    end
  endtask
  task automatic ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    chk("ack_clears_valid", 16'(key_valid), 16'd0);
  endtask
  task automatic release_all();
    down = '0;
    repeat (16) @(negedge clk);
  endtask
  initial begin
    key_ack = 1'b0;
    @(negedge clk);
    chk("rst_row_n", 16'(row_n), 16'hf);
    chk("rst_valid", 16'(key_valid), 16'd0);
    chk("rst_code", 16'(key_code), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_num", 16'(num), 16'd0);
    rst = 1'b0;
    // Idle scan: first tick after 4 clks, then one row step every 4 clks.
    repeat (3) @(negedge clk);
    chk("idle_row_pre", 16'(row_n), 16'hf);
    @(negedge clk);
    chk("idle_row0", 16'(row_n), 16'he);
    repeat (4) @(negedge clk);
    chk("idle_row1", 16'(row_n), 16'hd);
    repeat (4) @(negedge clk);
    chk("idle_row2", 16'(row_n), 16'hb);
    repeat (4) @(negedge clk);
    chk("idle_row3", 16'(row_n), 16'h7);
    repeat (4) @(negedge clk);
    chk("idle_wrap", 16'(row_n), 16'he);
    chk("idle_valid", 16'(key_valid), 16'd0);
    chk("idle_num", 16'(num), 16'd0);
    // Press 5, hold, ack, release.
    press(1, 1);
    repeat (40) @(negedge clk);
    chk("hold_valid", 16'(key_valid), 16'd1);
    chk("hold_overrun", 16'(overrun), 16'd0);
    ack();
    repeat (40) @(negedge clk);
    chk("hold_no_repeat", 16'(key_valid), 16'd0);
    chk("hold_row", 16'(row_n), 16'hd);
    down = '0;
    repeat (8) @(negedge clk);
    chk("release_hold_row", 16'(row_n), 16'hd);
    repeat (8) @(negedge clk);
    chk("release_exit_row", 16'(row_n), 16'hb);
    // Bounce on key 5: never stable for three ticks.
    align(1);
    for (int i = 0; i < 4; i++) begin
      down[5] = 1'b1;
      repeat (4) @(negedge clk);
      down[5] = 1'b0;
      repeat (4) @(negedge clk);
    end
    release_all();
    chk("bounce_valid", 16'(key_valid), 16'd0);
    chk("bounce_num", 16'(num), 16'(num_m));
    // Entry 1,2,3,4 then backspace and clear.
    press(0, 0); ack(); release_all();
    press(0, 1); ack(); release_all();
    press(0, 2); ack(); release_all();
    press(1, 0); ack(); release_all();
    chk("entry_num", 16'(num), 16'h234);
    press(3, 2); ack(); release_all();
    chk("hash_num", 16'(num), 16'h023);
    press(3, 0); ack(); release_all();
    chk("star_num", 16'(num), 16'h000);
    // 7 unacked, then 8 overruns.
    press(2, 0);
    release_all();
    press(2, 1);
    chk("ovr_flag", 16'(overrun), 16'd1);
    chk("ovr_code", 16'(key_code), 16'd7);
    chk("ovr_num", 16'(num), 16'h078);
    ack();
    chk("ovr_cleared", 16'(overrun), 16'd0);
    release_all();
    // Reset mid-debounce of key 9.
    align(2);
    down[10] = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_row_n", 16'(row_n), 16'hf);
    chk("midrst_valid", 16'(key_valid), 16'd0);
    chk("midrst_code", 16'(key_code), 16'd0);
    chk("midrst_overrun", 16'(overrun), 16'd0);
    chk("midrst_num", 16'(num), 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    num_m = '0;
    repeat (8) @(negedge clk);
    down = '0;
    repeat (40) @(negedge clk);
    chk("midrst_no_emit", 16'(key_valid), 16'd0);
    press(2, 2);
    ack();
    release_all();
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
